// File: rtl/led_pattern_gen_if.sv
// rtl/led_pattern_gen_if.sv - control inputs and LED bank outputs of led_pattern_gen
interface led_pattern_gen_if #(
  parameter int NB_LEDS = 4
);
  logic [2:0]         i_sw;
  logic               i_mode;
  logic [2:0]         i_sel_col;
  logic [NB_LEDS-1:0] o_led;
  logic [NB_LEDS-1:0] o_led_r;
  logic [NB_LEDS-1:0] o_led_g;
  logic [NB_LEDS-1:0] o_led_b;

  modport master (
    output i_sw, i_mode, i_sel_col,
    input  o_led, o_led_r, o_led_g, o_led_b
  );

  modport slave (
    input  i_sw, i_mode, i_sel_col,
    output o_led, o_led_r, o_led_g, o_led_b
  );
endinterface

// File: rtl/led_pattern_gen.sv
// rtl/led_pattern_gen.sv - prescaled shift/flash LED pattern steered onto an RGB bank
// Optional macro PINGPONG_EN: shift mode bounces between the end LEDs instead of wrapping.
module led_pattern_gen #(
  parameter int          NB_LEDS  = 4,
  parameter int          NB_CNT   = 32,
  parameter int unsigned CNT_LIM0 = 2**23,
  parameter int unsigned CNT_LIM1 = 2**22,
  parameter int unsigned CNT_LIM2 = 2**21,
  parameter int unsigned CNT_LIM3 = 2**20
) (
  input  logic           clock,
  input  logic           i_reset,
  led_pattern_gen_if.slave bus
);

  localparam logic [NB_LEDS-1:0] PAT_ONE = NB_LEDS'(1);
  localparam logic [NB_LEDS-1:0] PAT_ALL = '1;

`ifdef PINGPONG_EN
  typedef enum logic {DIR_LEFT = 1'b0, DIR_RIGHT = 1'b1} dir_e;
  dir_e dir_q, dir_d;
`endif

  logic [NB_CNT-1:0]  cnt_q, cnt_d;
  logic [NB_LEDS-1:0] pat_q, pat_d;
  logic               r_mode_q;
  logic [NB_LEDS-1:0] led_q, led_r_q, led_g_q, led_b_q;
  logic [NB_CNT-1:0]  lim_m1;
  logic               enable, tick, mode_chg;

  always_comb begin
    lim_m1 = NB_CNT'(CNT_LIM0 - 1);
    case (bus.i_sw[2:1])
      2'b00:   lim_m1 = NB_CNT'(CNT_LIM0 - 1);
      2'b01:   lim_m1 = NB_CNT'(CNT_LIM1 - 1);
      2'b10:   lim_m1 = NB_CNT'(CNT_LIM2 - 1);
      default: lim_m1 = NB_CNT'(CNT_LIM3 - 1);
    endcase
  end

  // >= rather than == so a speed switch to a shorter limit ticks immediately
  assign enable   = bus.i_sw[0];
  assign tick     = enable && (cnt_q >= lim_m1);
  assign mode_chg = (r_mode_q != bus.i_mode);

  always_comb begin
    cnt_d = cnt_q;
    pat_d = pat_q;
`ifdef PINGPONG_EN
    dir_d = dir_q;
`endif
    if (mode_chg) begin
      cnt_d = '0;
      pat_d = bus.i_mode ? PAT_ALL : PAT_ONE;
`ifdef PINGPONG_EN
      dir_d = DIR_LEFT;
`endif
    end else if (enable) begin
      if (tick) begin
        cnt_d = '0;
        if (r_mode_q) begin
          pat_d = ~pat_q;
        end else begin
`ifdef PINGPONG_EN
          // Reverse on the tick after an end LED lights, then step the other way
          if (dir_q == DIR_LEFT) begin
            if (pat_q[NB_LEDS-1]) begin
              dir_d = DIR_RIGHT;
              pat_d = pat_q >> 1;
            end else begin
              pat_d = pat_q << 1;
            end
          end else begin
            if (pat_q[0]) begin
              dir_d = DIR_LEFT;
              pat_d = pat_q << 1;
            end else begin
              pat_d = pat_q >> 1;
            end
          end
`else
          pat_d = {pat_q[NB_LEDS-2:0], pat_q[NB_LEDS-1]};
`endif
        end
      end else begin
        cnt_d = cnt_q + NB_CNT'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (i_reset) begin
      cnt_q    <= '0;
      pat_q    <= PAT_ONE;
      r_mode_q <= 1'b0;
      led_q    <= '0;
      led_r_q  <= '0;
      led_g_q  <= '0;
      led_b_q  <= '0;
`ifdef PINGPONG_EN
      dir_q    <= DIR_LEFT;
`endif
    end else begin
      cnt_q    <= cnt_d;
      pat_q    <= pat_d;
      r_mode_q <= bus.i_mode;
      led_q    <= pat_q;
      led_r_q  <= (bus.i_sel_col == 3'b001) ? pat_q : '0;
      led_g_q  <= (bus.i_sel_col == 3'b010) ? pat_q : '0;
      led_b_q  <= (bus.i_sel_col == 3'b100) ? pat_q : '0;
`ifdef PINGPONG_EN
      dir_q    <= dir_d;
`endif
    end
  end

  assign bus.o_led   = led_q;
  assign bus.o_led_r = led_r_q;
  assign bus.o_led_g = led_g_q;
  assign bus.o_led_b = led_b_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb/tb_led_pattern_gen.sv - directed and random checks of led_pattern_gen against a position-based model
module tb_led_pattern_gen;
  localparam int NB = 4;
  localparam int L0 = 4;
  localparam int L1 = 6;
  localparam int L2 = 3;
  localparam int L3 = 2;

  logic clock = 1'b0;
  logic i_reset;
  int   n_assert = 0;
  int   n_fail   = 0;

  led_pattern_gen_if #(.NB_LEDS(NB)) bus ();

  led_pattern_gen #(
    .NB_LEDS(NB), .NB_CNT(8),
    .CNT_LIM0(L0), .CNT_LIM1(L1), .CNT_LIM2(L2), .CNT_LIM3(L3)
  ) dut (
    .clock(clock),
    .i_reset(i_reset),
    .bus(bus)
  );

  always #5 clock = ~clock;

  // Model: lit LED as an index plus direction, flash as an on/off flag
  int          m_cnt = 0;
  int          m_pos = 0;
  int          m_dir = 1;
  bit          m_mode = 1'b0;
  bit          m_on = 1'b0;
  logic [NB-1:0] e_led = '0, e_r = '0, e_g = '0, e_b = '0;

  function automatic int lim_of(logic [1:0] s);
    case (s)
      2'd0:    return L0;
      2'd1:    return L1;
      2'd2:    return L2;
      default: return L3;
    endcase
  endfunction

  function automatic logic [NB-1:0] m_pat();
    logic [NB-1:0] one;
    one = 1;
    if (m_mode) return m_on ? '1 : '0;
    return one << m_pos;
  endfunction

  always @(posedge clock) begin
    logic [NB-1:0] old;
    bit tk;
    old = m_pat();
    if (i_reset) begin
      m_cnt = 0; m_pos = 0; m_dir = 1; m_mode = 0; m_on = 0;
      e_led = '0; e_r = '0; e_g = '0; e_b = '0;
    end else begin
      e_led = old;
      e_r = (bus.i_sel_col == 3'b001) ? old : '0;
      e_g = (bus.i_sel_col == 3'b010) ? old : '0;
      e_b = (bus.i_sel_col == 3'b100) ? old : '0;
      tk = bus.i_sw[0] && (m_cnt >= lim_of(bus.i_sw[2:1]) - 1);
      if (bus.i_mode != m_mode) begin
        m_mode = bus.i_mode; m_cnt = 0; m_pos = 0; m_dir = 1; m_on = 1;
      end else if (bus.i_sw[0]) begin
        if (tk) begin
          m_cnt = 0;
          if (m_mode) m_on = !m_on;
          else begin
`ifdef PINGPONG_EN
            if (m_pos + m_dir < 0 || m_pos + m_dir >= NB) m_dir = -m_dir;
            m_pos = m_pos + m_dir;
`else
            m_pos = (m_pos + 1) % NB;
`endif
          end
        end else m_cnt++;
      end
    end
  end

  task automatic chk(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clock);
    chk("o_led",   bus.o_led,   e_led);
    chk("o_led_r", bus.o_led_r, e_r);
    chk("o_led_g", bus.o_led_g, e_g);
    chk("o_led_b", bus.o_led_b, e_b);
  endtask

  task automatic wait_cnt(input int target, input int budget);
    for (int i = 0; i < budget && m_cnt != target; i++) cyc();
    n_assert++;
    assert (m_cnt == target) else begin
      n_fail++;
      $error("FAIL wait_cnt observed=%0d expected=%0d", m_cnt, target);
    end
  endtask

  logic [NB-1:0] tbl [$];
  logic [NB-1:0] p0;

  initial begin
    i_reset = 1'b1;
    bus.i_sw = 3'b001; bus.i_mode = 1'b0; bus.i_sel_col = 3'b001;
    repeat (3) @(negedge clock);
    chk("reset_led", bus.o_led,   4'b0000);
    chk("reset_r",   bus.o_led_r, 4'b0000);
    chk("reset_g",   bus.o_led_g, 4'b0000);
    chk("reset_b",   bus.o_led_b, 4'b0000);
    i_reset = 1'b0;

`ifdef PINGPONG_EN
    tbl = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010, 4'b0100};
`else
    tbl = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif
    cyc();
    chk("shift_0", bus.o_led, tbl[0]);
    chk("shift_r0", bus.o_led_r, tbl[0]);
    for (int k = 1; k < tbl.size(); k++) begin
      repeat (4) cyc();
      chk("shift_seq", bus.o_led, tbl[k]);
      chk("shift_g", bus.o_led_g, 4'b0000);
    end

    bus.i_mode = 1'b1;
    cyc();
    cyc();
    chk("flash_on", bus.o_led, 4'b1111);
    repeat (4) cyc();
    chk("flash_off", bus.o_led, 4'b0000);
    repeat (4) cyc();
    chk("flash_on2", bus.o_led, 4'b1111);

    bus.i_sw = 3'b000;
    cyc();
    p0 = m_pat();
    repeat (20) cyc();
    chk("freeze", bus.o_led, p0);

    bus.i_mode = 1'b0;
    bus.i_sw = 3'b011;
    wait_cnt(3, 20);
    p0 = m_pat();
    bus.i_sw = 3'b111;
    cyc();
    cyc();
`ifndef PINGPONG_EN
    chk("speed_tick", bus.o_led, {p0[NB-2:0], p0[NB-1]});
`endif
    repeat (6) cyc();

    foreach (tbl[k]) begin
      case (k % 5)
        0: bus.i_sel_col = 3'b001;
        1: bus.i_sel_col = 3'b010;
        2: bus.i_sel_col = 3'b100;
        3: bus.i_sel_col = 3'b011;
        default: bus.i_sel_col = 3'b000;
      endcase
      cyc();
      if (k % 5 >= 3) begin
        chk("inv_sel_r", bus.o_led_r, 4'b0000);
        chk("inv_sel_g", bus.o_led_g, 4'b0000);
        chk("inv_sel_b", bus.o_led_b, 4'b0000);
      end
    end

    bus.i_sw = 3'b001;
    bus.i_sel_col = 3'b001;
    wait_cnt(L0 - 1, 20);
    bus.i_mode = 1'b1;
    cyc();
    cyc();
    chk("tick_vs_mode", bus.o_led, 4'b1111);

    wait_cnt(L0 - 1, 20);
    i_reset = 1'b1;
    bus.i_mode = 1'b0;
    cyc();
    chk("rst_tick_led", bus.o_led,   4'b0000);
    chk("rst_tick_r",   bus.o_led_r, 4'b0000);
    i_reset = 1'b0;
    cyc();
    chk("rst_tick_pat", bus.o_led,   4'b0001);
    chk("rst_tick_r1",  bus.o_led_r, 4'b0001);

    i_reset = 1'b1;
    bus.i_mode = 1'b1;
    cyc();
    i_reset = 1'b0;
    cyc();
    cyc();
    chk("mode_in_reset", bus.o_led, 4'b1111);

    for (int n = 0; n < 800; n++) begin
      cyc();
      i_reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 39) == 0) bus.i_mode = ~bus.i_mode;
      if ($urandom_range(0, 15) == 0) bus.i_sw = {2'($urandom_range(0, 3)), 1'($urandom_range(0, 7) != 0)};
      if ($urandom_range(0, 7) == 0) bus.i_sel_col = 3'($urandom_range(0, 7));
    end
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
